i2s_audio_rx: RTL and testbench

- Serial PCM receiver: the receive end of the I2S link our ak4432_audio encoder drives (BCLK, LRCLK, SDATA).
- Oversamples the three externally clocked lines in the system clock domain and recovers signed left/right words.
- Delivers a one-cycle strobe per stereo frame, for audio_in / tape-input paths on boards with a codec ADC or external I2S source.

---
 rtl/i2s_audio_rx_pkg.sv | 7 +
 rtl/i2s_audio_rx_sync.sv | 28 ++
 rtl/i2s_audio_rx.sv | 98 +++++++++
 tb/tb_i2s_audio_rx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/i2s_audio_rx_pkg.sv
// i2s_audio_rx_pkg: shared receiver states, channel codes and bit counter width
package i2s_audio_rx_pkg;
  typedef enum logic [1:0] {S_SYNC, S_LEFT, S_RIGHT_WAIT, S_RIGHT} state_t;
  localparam logic CH_LEFT = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
  localparam int CNT_W = 6;
endpackage

// File: rtl/i2s_audio_rx_sync.sv
// i2s_rx_sync: two-flop synchronizers for bclk/lrclk/sdata plus bclk rise detect
module i2s_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i2s_bclk,
  input  logic i2s_lrclk,
  input  logic i2s_sdata,
  output logic bclk_rise,
  output logic lrclk_s,
  output logic sdata_s
);
  logic [2:0] r_bclk;
  logic [1:0] r_lr;
  logic [1:0] r_sd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_bclk <= '0;
      r_lr   <= '0;
      r_sd   <= '0;
    end else begin
      r_bclk <= {r_bclk[1:0], i2s_bclk};
      r_lr   <= {r_lr[0], i2s_lrclk};
      r_sd   <= {r_sd[0], i2s_sdata};
    end
  assign bclk_rise = r_bclk[1] & ~r_bclk[2];
  assign lrclk_s   = r_lr[1];
  assign sdata_s   = r_sd[1];
endmodule

// File: rtl/i2s_audio_rx.sv
// i2s_audio_rx: oversampling I2S receiver; define I2S_RX_MONO_MIX_EN for (L+R)/2 on pcm_mono
module i2s_audio_rx
  import i2s_audio_rx_pkg::*;
#(
  parameter int audio_bits = 16,
  parameter int timeout_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_sdata,
  output logic [audio_bits-1:0] pcm_l,
  output logic [audio_bits-1:0] pcm_r,
  output logic [audio_bits-1:0] pcm_mono,
  output logic                  pcm_valid,
  output logic                  locked,
  output logic                  short_slot
);
  localparam int WD_W = $clog2(timeout_cycles);
  localparam logic [CNT_W-1:0] AB = CNT_W'(audio_bits);
  logic w_rise, w_lr, w_sd, w_slot_end, w_short;
  logic [CNT_W-1:0] w_shamt;
  logic [audio_bits-1:0] w_word, w_mono;
  state_t r_state;
  logic r_lr_prev;
  logic [audio_bits-1:0] r_shreg, r_hold_l;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WD_W-1:0] r_wd;
  i2s_rx_sync u_sync (
    .clk(clk), .reset(reset), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .bclk_rise(w_rise), .lrclk_s(w_lr), .sdata_s(w_sd)
  );
  assign w_slot_end = w_rise && (w_lr != r_lr_prev);
  assign w_short = r_bit_cnt < AB;
  assign w_shamt = w_short ? AB - r_bit_cnt : '0;
  assign w_word = r_shreg << w_shamt;
`ifdef I2S_RX_MONO_MIX_EN
  logic [audio_bits:0] w_sum;
  assign w_sum = {r_hold_l[audio_bits-1], r_hold_l} + {w_word[audio_bits-1], w_word};
  assign w_mono = w_sum[audio_bits:1];
`else
  assign w_mono = r_hold_l;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= S_SYNC;
      r_lr_prev  <= 1'b0;
      r_shreg    <= '0;
      r_hold_l   <= '0;
      r_bit_cnt  <= '0;
      r_wd       <= '0;
      pcm_l      <= '0;
      pcm_r      <= '0;
      pcm_mono   <= '0;
      pcm_valid  <= 1'b0;
      locked     <= 1'b0;
      short_slot <= 1'b0;
    end else begin
      pcm_valid  <= 1'b0;
      short_slot <= 1'b0;
      if (w_rise) begin
        r_wd      <= '0;
        r_lr_prev <= w_lr;
        if (w_slot_end) begin
          // the bit on the boundary edge is already the new slot's MSB
          r_shreg    <= {{(audio_bits-1){1'b0}}, w_sd};
          r_bit_cnt  <= CNT_W'(1);
          short_slot <= (r_state != S_SYNC) && w_short;
          case (r_state)
            S_SYNC:       r_state <= (w_lr == CH_RIGHT) ? S_RIGHT_WAIT : S_LEFT;
            S_LEFT: begin
              r_hold_l <= w_word;
              r_state  <= S_RIGHT;
            end
            S_RIGHT_WAIT: r_state <= S_LEFT;
            S_RIGHT: begin
              pcm_l     <= r_hold_l;
              pcm_r     <= w_word;
              pcm_mono  <= w_mono;
              pcm_valid <= 1'b1;
              locked    <= 1'b1;
              r_state   <= S_LEFT;
            end
            default:      r_state <= S_SYNC;
          endcase
        end else begin
          if (w_short) r_shreg <= {r_shreg[audio_bits-2:0], w_sd};
          if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else if (r_wd == WD_W'(timeout_cycles - 1)) begin
        r_state <= S_SYNC;
        locked  <= 1'b0;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
endmodule

// File: tb/tb_i2s_audio_rx.sv
// tb_i2s_audio_rx: directed I2S frames with hand-computed expectations for i2s_audio_rx
module tb_i2s_audio_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_sdata = 1'b0;
  logic [15:0] pcm_l, pcm_r, pcm_mono;
  logic pcm_valid, locked, short_slot;
  int n_assert = 0, n_fail = 0;
  int n_valid = 0, n_short = 0, n_double = 0, v0 = 0, s0 = 0;
  logic prev_v = 1'b0;

  i2s_audio_rx #(.audio_bits(16), .timeout_cycles(1024)) dut (
    .clk(clk), .reset(reset), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_mono(pcm_mono),
    .pcm_valid(pcm_valid), .locked(locked), .short_slot(short_slot)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pcm_valid) begin
      n_valid++;
      if (prev_v) n_double++;
    end
    if (short_slot) n_short++;
    prev_v = pcm_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    @(negedge clk);
    i2s_bclk = 1'b0; i2s_lrclk = lr; i2s_sdata = d;
    repeat (7) @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(lr, w[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pcm_l", pcm_l, 0);
    check("rst_pcm_r", pcm_r, 0);
    check("rst_mono", pcm_mono, 0);
    check("rst_valid", pcm_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_short", short_slot, 0);
    reset = 1'b0;
    // 32-bit slots: frame 1 is SYNC/RIGHT_WAIT, frame 2 is the first full pair
    send_frame({16'h8001, 16'h0}, {16'h7FFE, 16'h0}, 32);
    send_frame({16'h8001, 16'h0}, {16'h7FFE, 16'h0}, 32);
    check("pre_lock_valid_cnt", n_valid, 0);
    check("pre_lock_locked", locked, 0);
    send_slot(1'b0, {16'h8001, 16'h0}, 32);
    check("st_valid_cnt", n_valid, 1);
    check("st_pcm_l", pcm_l, 32'h8001);
    check("st_pcm_r", pcm_r, 32'h7FFE);
    check("st_locked", locked, 1);
    check("st_no_short", n_short, 0);
    send_slot(1'b1, {16'h7FFE, 16'h0}, 32);
    v0 = n_valid; s0 = n_short;
    send_frame(32'hABC, 32'h123, 12);
    send_frame(32'hABC, 32'h123, 12);
    send_slot(1'b0, 32'hABC, 12);
    check("sh_valid_delta", n_valid - v0, 3);
    check("sh_short_delta", n_short - s0, 4);
    check("sh_pcm_l", pcm_l, 32'hABC0);
    check("sh_pcm_r", pcm_r, 32'h1230);
    send_slot(1'b1, 32'h123, 12);
    send_frame(32'h7FFF, 32'h7FFF, 16);
    send_slot(1'b0, 32'h8000, 16);
    check("m1_pcm_l", pcm_l, 32'h7FFF);
    check("m1_mono", pcm_mono, 32'h7FFF);
    send_slot(1'b1, 32'hFFFF, 16);
    send_slot(1'b0, 32'h0001, 16);
    check("m2_pcm_r", pcm_r, 32'hFFFF);
`ifdef I2S_RX_MONO_MIX_EN
    check("m2_mono", pcm_mono, 32'hBFFF);
`else
    check("m2_mono", pcm_mono, 32'h8000);
`endif
    send_slot(1'b1, 32'h0000, 16);
    send_slot(1'b0, 32'h0000, 16);
    check("m3_pcm_l", pcm_l, 32'h0001);
    check("m3_pcm_r", pcm_r, 32'h0000);
`ifdef I2S_RX_MONO_MIX_EN
    check("m3_mono", pcm_mono, 32'h0000);
`else
    check("m3_mono", pcm_mono, 32'h0001);
`endif
    // stop bclk high after a right slot; rise is processed on the 3rd posedge
    send_slot(1'b1, 32'h1234, 16);
    v0 = n_valid;
    repeat (1018) @(negedge clk);
    check("to_locked_before", locked, 1);
    @(negedge clk);
    check("to_locked_after", locked, 0);
    check("to_hold_l", pcm_l, 32'h0001);
    check("to_hold_r", pcm_r, 32'h0000);
    check("to_no_valid", n_valid - v0, 0);
    send_frame(32'h1111, 32'h2222, 16);
    check("rs_locked_pre", locked, 0);
    send_slot(1'b0, 32'h5A5A, 16);
    check("rs_locked", locked, 1);
    check("rs_pcm_l", pcm_l, 32'h1111);
    check("rs_pcm_r", pcm_r, 32'h2222);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ar_pcm_l", pcm_l, 0);
    check("ar_pcm_r", pcm_r, 0);
    check("ar_mono", pcm_mono, 0);
    check("ar_locked", locked, 0);
    @(negedge clk);
    reset = 1'b0;
    v0 = n_valid;
    send_slot(1'b1, 32'hFFFF, 16);
    send_frame(32'h5555, 32'hAAAA, 16);
    check("ar_no_valid", n_valid - v0, 0);
    check("ar_pcm_l_held", pcm_l, 0);
    send_slot(1'b0, 32'h0000, 16);
    check("ar_valid_delta", n_valid - v0, 1);
    check("ar_pcm_l", pcm_l, 32'h5555);
    check("ar_pcm_r", pcm_r, 32'hAAAA);
    check("ar_relock", locked, 1);
    @(negedge clk);
    reset = 1'b1;
    i2s_lrclk = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    reset = 1'b0;
    send_slot(1'b1, 32'h15, 5);
    v0 = n_valid;
    send_frame(32'h0F0F, 32'hF0F0, 16);
    check("mf_no_valid", n_valid - v0, 0);
    check("mf_locked_pre", locked, 0);
    send_slot(1'b0, 32'h0000, 16);
    check("mf_valid_delta", n_valid - v0, 1);
    check("mf_pcm_l", pcm_l, 32'h0F0F);
    check("mf_pcm_r", pcm_r, 32'hF0F0);
    check("valid_single_cycle", n_double, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
